data_mem_arbiter: RTL

Two-port arbiter and access sequencer for the 64×32 single-port data memory. It lets the CPU load/store unit (port 0) and a debug/loader port (port 1) share one memory. It serialises their requests and drives the memory's read-enable, write-enable, address and write-data lines. For reads, it captures the combinational read data into a register and returns it with a one-cycle done pulse. It sits between the requesters and the data memory; the memory itself is not inside this block.

---
 rtl/data_mem_arb_pkg.sv | 21 ++
 rtl/data_mem_arbiter_arb2.sv | 36 +++
 rtl/data_mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The command struct is sized from the package defaults, so the top parameters must keep them.
package data_mem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  port;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/data_mem_arbiter_arb2.sv
// Combinational two-requester arbiter producing a one-hot winner.
// DATA_MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] win
);

`ifdef DATA_MEM_ARB_RR_EN
    // On a tie the port that was not granted last wins.
    always_comb begin
        win = 2'b00;
        if (en) begin
            case (req)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = last_gnt ? 2'b01 : 2'b10;
                default: win = 2'b00;
            endcase
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        win = 2'b00;
        if (en) begin
            if (req[0])      win = 2'b01;
            else if (req[1]) win = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t     state, state_nxt;
    cmd_t       cmd;
    logic [1:0] req_elig;
    logic [1:0] win;
    logic       arb_en;
    logic       grant;
    logic       last_gnt;

    assign arb_en = (state == IDLE) || (state == RESP);

    // The port finishing in RESP must not win again on the same edge.
    always_comb begin
        req_elig = req;
        if (state == RESP) req_elig[cmd.port] = 1'b0;
    end

    arb2 u_arb2 (
        .req      (req_elig),
        .last_gnt (last_gnt),
        .en       (arb_en),
        .win      (win)
    );

    assign grant = |win;

`ifdef DATA_MEM_ARB_RR_EN
    // Reset value 1 makes port 0 the first winner on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_gnt <= 1'b1;
        else if (grant) last_gnt <= win[1];
    end
`else
    assign last_gnt = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS: begin
                state_nxt = RESP;
                mem_read  = !cmd.we;
                mem_write = cmd.we;
            end
            RESP:    state_nxt = grant ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd   <= '0;
            gnt   <= 2'b00;
            done  <= 2'b00;
            rdata <= '0;
        end else begin
            gnt  <= win;
            done <= (state == ACCESS) ? (cmd.port ? 2'b10 : 2'b01) : 2'b00;
            if (grant) begin
                cmd.port  <= win[1];
                cmd.we    <= win[1] ? we[1]  : we[0];
                cmd.addr  <= win[1] ? addr1  : addr0;
                cmd.wdata <= win[1] ? wdata1 : wdata0;
            end
            if (state == ACCESS && !cmd.we) rdata <= mem_rdata;
        end
    end

    // The command register only changes on a grant, so the memory lines hold between accesses.
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

endmodule
